// File: rtl/multi_switch_debouncer.sv
// N-channel switch debouncer: per-channel 2-FF synchroniser, stability filter,
// rise/fall pulses and a tick-based long-press detector sharing one tick generator.
module multi_switch_debouncer #(
   parameter int NUM_CH           = 4,
   parameter int TIMER_VALUE      = 100000,
   parameter int LONG_PRESS_TICKS = 20,
   parameter bit ACTIVE_LOW       = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] data_in,
   output logic [NUM_CH-1:0] data_out,
   output logic [NUM_CH-1:0] rise_pulse,
   output logic [NUM_CH-1:0] fall_pulse,
   output logic [NUM_CH-1:0] long_press,
   output logic [NUM_CH-1:0] long_held
);

   localparam int CNT_W  = $clog2(TIMER_VALUE);
   localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMER_VALUE - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_TICKS - 1);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_COUNTING = 1'b1
   } deb_state_t;

   logic [NUM_CH-1:0] pin_asserted;
   logic [NUM_CH-1:0] sync1_reg;
   logic [NUM_CH-1:0] sync2_reg;
   logic [CNT_W-1:0]  tick_cnt_reg;
   logic              tick;

   assign pin_asserted = ACTIVE_LOW ? ~data_in : data_in;

   // Synchroniser resets to "not pressed" so leaving reset cannot fake an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= pin_asserted;
         sync2_reg <= sync1_reg;
      end
   end

   assign tick = (tick_cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt_reg <= '0;
      end else if (tick) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      deb_state_t        state_reg, state_next;
      logic [CNT_W-1:0]  cnt_reg, cnt_next;
      logic              level_reg, level_next;
      logic              rise_reg, rise_next;
      logic              fall_reg, fall_next;
      logic [HOLD_W-1:0] hold_reg, hold_next;
      logic              lp_reg, lp_next;
      logic              held_reg, held_next;
      logic              mismatch;

      assign mismatch = sync2_reg[gi] ^ level_reg;

      always_comb begin
         state_next = state_reg;
         cnt_next   = cnt_reg;
         level_next = level_reg;
         rise_next  = 1'b0;
         fall_next  = 1'b0;
         hold_next  = hold_reg;
         lp_next    = 1'b0;
         held_next  = held_reg;

         case (state_reg)
            ST_STABLE: begin
               cnt_next = '0;
               if (mismatch) begin
                  state_next = ST_COUNTING;
               end
            end
            ST_COUNTING: begin
               if (!mismatch) begin
                  cnt_next   = '0;
                  state_next = ST_STABLE;
               end else if (cnt_reg == CNT_LAST) begin
                  level_next = sync2_reg[gi];
                  rise_next  = sync2_reg[gi];
                  fall_next  = ~sync2_reg[gi];
                  cnt_next   = '0;
                  state_next = ST_STABLE;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               cnt_next   = '0;
               state_next = ST_STABLE;
            end
         endcase

         // A release landing on the final tick wins: no long press is reported.
         if (!level_reg) begin
            hold_next = '0;
            held_next = 1'b0;
         end else if (tick && (hold_reg != HOLD_MAX)) begin
            hold_next = hold_reg + HOLD_W'(1);
            if ((hold_reg == HOLD_PRE) && !fall_next) begin
               lp_next   = 1'b1;
               held_next = 1'b1;
            end
         end
         if (fall_next) begin
            held_next = 1'b0;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_reg <= ST_STABLE;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            hold_reg  <= '0;
            lp_reg    <= 1'b0;
            held_reg  <= 1'b0;
         end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            hold_reg  <= hold_next;
            lp_reg    <= lp_next;
            held_reg  <= held_next;
         end
      end

      assign data_out[gi]   = level_reg;
      assign rise_pulse[gi] = rise_reg;
      assign fall_pulse[gi] = fall_reg;
      assign long_press[gi] = lp_reg;
      assign long_held[gi]  = held_reg;
   end

endmodule
